// File: rtl/ps2_rx_sequencer.sv
// PS/2 receive controller: line conditioning, frame sequencing, E0/F0 prefix
// decoding and a small key-event FIFO with a valid/ready handshake.
module ps2_rx_sequencer #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       evt_ready_i,
  input  logic       clr_err_i,
  output logic       evt_valid_o,
  output logic [7:0] evt_code_o,
  output logic       evt_ext_o,
  output logic       evt_brk_o,
  output logic       frame_err_o,
  output logic       fifo_ovf_o
);
  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} frameState_e;
  typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXT_BRK} decState_e;

  logic [1:0]     clkSync_q, dataSync_q;
  logic [FCW-1:0] clkCnt_q, dataCnt_q;
  logic           clkFilt_q, dataFilt_q, clkFiltPrev_q, fallPulse_q;

  // Idle bus is high, so synchronizers and filters come out of reset at 1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clkSync_q     <= 2'b11;
      dataSync_q    <= 2'b11;
      clkCnt_q      <= '0;
      dataCnt_q     <= '0;
      clkFilt_q     <= 1'b1;
      dataFilt_q    <= 1'b1;
      clkFiltPrev_q <= 1'b1;
      fallPulse_q   <= 1'b0;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk_i};
      dataSync_q <= {dataSync_q[0], ps2_data_i};
      if (clkSync_q[1] == clkFilt_q) begin
        clkCnt_q <= '0;
      end else if (clkCnt_q == FCW'(FILT_LEN - 1)) begin
        clkFilt_q <= clkSync_q[1];
        clkCnt_q  <= '0;
      end else begin
        clkCnt_q <= clkCnt_q + 1'b1;
      end
      if (dataSync_q[1] == dataFilt_q) begin
        dataCnt_q <= '0;
      end else if (dataCnt_q == FCW'(FILT_LEN - 1)) begin
        dataFilt_q <= dataSync_q[1];
        dataCnt_q  <= '0;
      end else begin
        dataCnt_q <= dataCnt_q + 1'b1;
      end
      clkFiltPrev_q <= clkFilt_q;
      fallPulse_q   <= clkFiltPrev_q & ~clkFilt_q;
    end
  end

  frameState_e    fState_q, fState_d;
  logic [3:0]     bitCnt_q, bitCnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [TCW-1:0] toCnt_q, toCnt_d;
  logic           byteOk_q, byteOk_d, frameBad_q, frameBad_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fState_q   <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      toCnt_q    <= '0;
      byteOk_q   <= 1'b0;
      frameBad_q <= 1'b0;
    end else begin
      fState_q   <= fState_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      toCnt_q    <= toCnt_d;
      byteOk_q   <= byteOk_d;
      frameBad_q <= frameBad_d;
    end
  end

  // bitCnt_q holds the index of the next bit expected on a falling edge.
  always_comb begin
    fState_d   = fState_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    toCnt_d    = toCnt_q;
    byteOk_d   = 1'b0;
    frameBad_d = 1'b0;
    case (fState_q)
      IDLE: begin
        toCnt_d = '0;
        if (fallPulse_q && !dataFilt_q) begin
          fState_d = SHIFT;
          bitCnt_d = 4'd1;
        end
      end
      SHIFT: begin
        if (fallPulse_q) begin
          toCnt_d  = '0;
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q <= 4'd8) begin
            shift_d = {dataFilt_q, shift_q[7:1]};
          end else if (bitCnt_q == 4'd9) begin
            parity_d = dataFilt_q;
          end else begin
            fState_d = IDLE;
            if (((^shift_q) ^ parity_q) && dataFilt_q) byteOk_d = 1'b1;
            else frameBad_d = 1'b1;
          end
        end else if (toCnt_q == TCW'(TIMEOUT_CYC - 1)) begin
          fState_d   = IDLE;
          frameBad_d = 1'b1;
        end else begin
          toCnt_d = toCnt_q + 1'b1;
        end
      end
    endcase
  end

  decState_e  dState_q, dState_d;
  logic       push_q, push_d;
  logic [9:0] pushData_q, pushData_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dState_q   <= D_BASE;
      push_q     <= 1'b0;
      pushData_q <= '0;
    end else begin
      dState_q   <= dState_d;
      push_q     <= push_d;
      pushData_q <= pushData_d;
    end
  end

  always_comb begin
    dState_d   = dState_q;
    push_d     = 1'b0;
    pushData_d = pushData_q;
    if (frameBad_q) begin
      dState_d = D_BASE;
    end else if (byteOk_q) begin
      if (shift_q == 8'hE0) begin
        dState_d = D_EXT;
      end else if (shift_q == 8'hF0) begin
        dState_d = (dState_q == D_EXT || dState_q == D_EXT_BRK) ? D_EXT_BRK : D_BRK;
      end else begin
        push_d     = 1'b1;
        pushData_d = {shift_q, (dState_q == D_EXT || dState_q == D_EXT_BRK),
                      (dState_q == D_BRK || dState_q == D_EXT_BRK)};
        dState_d   = D_BASE;
      end
    end
  end

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q;
  logic          pop, full, doPush;
  logic          frameErr_q, ovf_q;

  assign evt_valid_o = (count_q != '0);
  assign pop         = evt_valid_o && evt_ready_i;
  assign full        = (count_q == DEPTH_C);
  assign doPush      = push_q && (!full || pop);

  assign {evt_code_o, evt_ext_o, evt_brk_o} = evt_valid_o ? mem_q[rdPtr_q] : 10'd0;
  assign frame_err_o = frameErr_q;
  assign fifo_ovf_o  = ovf_q;

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_q;
  end

  // A set in the same cycle as clr_err keeps the sticky flag high.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      frameErr_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      frameErr_q <= frameBad_q | (frameErr_q & ~clr_err_i);
      ovf_q      <= (push_q & full & ~pop) | (ovf_q & ~clr_err_i);
    end
  end
endmodule

// File: doc/ps2_rx_sequencer.md
Name: ps2_rx_sequencer

Overview:
- Single-clock-domain PS/2 receive controller. It oversamples the raw ps2_clk/ps2_data lines on the system clock and sequences frame reception: start, 8 data bits LSB first, odd parity, stop.
- It also sequences scan-code prefix decoding (E0 extended, F0 break) and buffers decoded key events in a small FIFO with a valid/ready handshake.
- Sits between the keyboard pins and display/consumer logic, replacing ps2_clk-clocked capture.

Parameters:
- FILT_LEN, 4: consecutive equal synchronized samples required before the filtered line changes (glitch filter).
- TIMEOUT_CYC, 100000: max clk cycles allowed between falling edges inside a frame before abort.
- FIFO_DEPTH, 4: event FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset; asynchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous.
- ps2_data  input  1  raw PS/2 data line, asynchronous.
- evt_ready  input  1  consumer accepts head event.
- clr_err  input  1  clears sticky error flags.
- evt_valid  output  1  FIFO non-empty.
- evt_code  output  8  head event scan code.
- evt_ext  output  1  head event was E0-prefixed.
- evt_brk  output  1  head event was F0-prefixed (key release).
- frame_err  output  1  sticky: parity, stop or timeout error seen.
- fifo_ovf  output  1  sticky: event dropped because FIFO was full.

Behaviour:
- Reset: all outputs 0. Frame FSM in IDLE, decoder in D_BASE, FIFO empty, filters preset to 1 (idle bus).
- Conditioning: 2-flop synchronizer per line, then a counter filter; the filtered value changes only after FILT_LEN identical samples. fall_pulse is a one-cycle registered pulse on a filtered clk 1->0 transition. Data is sampled from filtered data in the same cycle.
- Frame FSM states IDLE, SHIFT.
  - IDLE: on fall_pulse with data=0, go to SHIFT with bitcnt=1. With data=1, the start bit is invalid; stay in IDLE, no error.
  - SHIFT: each fall_pulse shifts in one bit. Bits 1..8 are data LSB first, bit 9 is parity, bit 10 is stop.
  - On bit 10: frame OK iff (^data ^ parity)==1 and stop==1. Return to IDLE.
- Frame result:
  - OK frame: byte_ok pulses 1 cycle after the stop fall_pulse.
  - Bad frame: frame_err sets, no byte is passed on, decoder forced to D_BASE.
- Timeout: a counter clears on each fall_pulse and counts while in SHIFT. Reaching TIMEOUT_CYC aborts to IDLE, sets frame_err and forces the decoder to D_BASE.
- Decoder FSM states D_BASE, D_EXT, D_BRK, D_EXT_BRK; acts on byte_ok.
  - D_BASE: E0 goes to D_EXT; F0 goes to D_BRK.
  - D_EXT: F0 goes to D_EXT_BRK.
  - E0 in D_EXT/D_BRK/D_EXT_BRK restarts to D_EXT; F0 in D_BRK/D_EXT_BRK stays in the same state.
  - Any other byte pushes {code, ext, brk} per the current state, then returns to D_BASE.
- Latency: the push occurs 2 cycles after the stop fall_pulse. evt_valid is high from the next cycle when the FIFO was empty.
- FIFO:
  - Pop when evt_valid && evt_ready. evt_code/evt_ext/evt_brk show the head entry and are stable while evt_valid && !evt_ready.
  - Push while full without a same-cycle pop drops the new event and sets fifo_ovf.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is log2(FIFO_DEPTH)+1.
- clr_err clears both sticky flags. A new error in the same cycle wins, so the flag stays set.
- Reset mid-frame discards the partial frame, the decoder state and all FIFO contents.

Test Plan:
- Reset, then send 0x16 frame (bits 0,0,1,1,0,1,0,0,0,P=0,S=1), evt_ready=1 -> exactly one event: code=0x16, ext=0, brk=0, evt_valid high for 1 cycle, no errors.
- Send E0, F0, 75 -> single event code=0x75, ext=1, brk=1. Then F0, 16 -> code=0x16, ext=0, brk=1.
- Send 0x16 with parity=1 -> frame_err=1, no event. Follow with a good 0x1E -> event 0x1E. Pulse clr_err -> frame_err=0.
- Send start plus 4 data bits, then idle TIMEOUT_CYC+10 cycles -> frame_err=1, FSM in IDLE. Next good 0x45 decoded correctly.
- evt_ready=0, send 5 make codes 16,1E,26,25,2E -> fifo_ovf=1. Raising evt_ready pops 16,1E,26,25 in order, then evt_valid=0.
- Assert rstn low after 6 bits of a frame -> all outputs 0, FIFO empty. Next complete 0x3E frame decoded as 0x3E. Also inject 1-cycle ps2_clk glitches shorter than FILT_LEN -> no extra bits shifted.
